// File: rtl/gpu_pixel_writer_if.sv
// Bundles the pixel input stream (valid/ready) and the framebuffer SRAM port (4-phase req/ack).
// master = rasteriser + SRAM side, slave = the pixel writer.
interface gpu_pixel_writer_if #(
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int CHANNEL_BITS = 8,
  parameter int ADDR_BITS    = 19
);
  logic                      px_valid;
  logic                      px_ready;
  logic [WIDTH_BITS-1:0]     px_x;
  logic [HEIGHT_BITS-1:0]    px_y;
  logic [CHANNEL_BITS-1:0]   px_r;
  logic [CHANNEL_BITS-1:0]   px_g;
  logic [CHANNEL_BITS-1:0]   px_b;
  logic                      mem_req;
  logic                      mem_ack;
  logic [ADDR_BITS-1:0]      mem_addr;
  logic [3*CHANNEL_BITS-1:0] mem_data;

  modport master (
    output px_valid, px_x, px_y, px_r, px_g, px_b, mem_ack,
    input  px_ready, mem_req, mem_addr, mem_data
  );

  modport slave (
    input  px_valid, px_x, px_y, px_r, px_g, px_b, mem_ack,
    output px_ready, mem_req, mem_addr, mem_data
  );
endinterface

// File: rtl/gpu_pixel_writer.sv
// Pixel stream sink: clips off-screen pixels, converts to linear framebuffer addresses,
// buffers them in a small FIFO and drains it to SRAM with a 4-phase req/ack handshake.
module gpu_pixel_writer #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int CHANNEL_BITS = 8,
  parameter int ADDR_BITS    = 19,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  gpu_pixel_writer_if.slave   bus,
  output logic                idle,
  output logic [15:0]         drop_count
);

  localparam int PTR_BITS  = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS  = PTR_BITS + 1;
  localparam int DATA_BITS = 3 * CHANNEL_BITS;

  localparam logic [31:0]          WIDTH_U  = 32'(WIDTH);
  localparam logic [31:0]          HEIGHT_U = 32'(HEIGHT);
  localparam logic [ADDR_BITS-1:0] WIDTH_A  = ADDR_BITS'(WIDTH);
  localparam logic [CNT_BITS-1:0]  DEPTH_C  = CNT_BITS'(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                state_reg;
  logic                  mem_req_reg;
  logic [ADDR_BITS-1:0]  mem_addr_reg;
  logic [DATA_BITS-1:0]  mem_data_reg;

  logic [PTR_BITS-1:0]   wr_ptr_reg;
  logic [PTR_BITS-1:0]   rd_ptr_reg;
  logic [CNT_BITS-1:0]   count_reg;
  logic [CNT_BITS-1:0]   count_next;
  logic [15:0]           drop_count_reg;
  logic [15:0]           drop_count_next;

  entry_t                fifo_mem [FIFO_DEPTH];

  logic [WIDTH_BITS-1:0]  x_in;
  logic [HEIGHT_BITS-1:0] y_in;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   accept;
  logic                   on_screen;
  logic                   push;
  logic                   pop;
  logic                   drop;
  entry_t                 new_entry;
  entry_t                 head_entry;

  assign x_in       = bus.px_x;
  assign y_in       = bus.px_y;
  // full comes from the registered count only, so a same-cycle pop never frees a slot early
  assign fifo_full  = (count_reg == DEPTH_C);
  assign fifo_empty = (count_reg == '0);

  assign accept     = bus.px_valid && !fifo_full;
  assign on_screen  = (32'(x_in) < WIDTH_U) && (32'(y_in) < HEIGHT_U);
  assign push       = accept && on_screen;
  assign drop       = accept && !on_screen;
  assign pop        = (state_reg == ST_REQ) && bus.mem_ack;

  assign new_entry.addr = ADDR_BITS'(y_in) * WIDTH_A + ADDR_BITS'(x_in);
  assign new_entry.data = {bus.px_r, bus.px_g, bus.px_b};
  assign head_entry     = fifo_mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_BITS'(1);
      2'b01:   count_next = count_reg - CNT_BITS'(1);
      default: count_next = count_reg;
    endcase
  end

  always_comb begin
    drop_count_next = drop_count_reg;
    if (drop && (drop_count_reg != 16'hFFFF)) begin
      drop_count_next = drop_count_reg + 16'd1;
    end
  end

  // Storage is not reset: count and pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= new_entry;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      drop_count_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_BITS'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_BITS'(1);
      end
      count_reg      <= count_next;
      drop_count_reg <= drop_count_next;
    end
  end

  // Write FSM; mem_addr/mem_data are only reloaded when leaving IDLE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg    <= ST_IDLE;
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= '0;
      mem_data_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!fifo_empty) begin
            mem_addr_reg <= head_entry.addr;
            mem_data_reg <= head_entry.data;
            mem_req_reg  <= 1'b1;
            state_reg    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.mem_ack) begin
            mem_req_reg <= 1'b0;
            state_reg   <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!bus.mem_ack) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          mem_req_reg <= 1'b0;
          state_reg   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.px_ready = !fifo_full;
  assign bus.mem_req  = mem_req_reg;
  assign bus.mem_addr = mem_addr_reg;
  assign bus.mem_data = mem_data_reg;
  assign idle         = fifo_empty && (state_reg == ST_IDLE);
  assign drop_count   = drop_count_reg;

endmodule

// File: doc/gpu_pixel_writer.md
Name: gpu_pixel_writer

Overview:
- Consumer end of the pixel stream produced by the GPU rasterisers (line and future shape units).
- Accepts (X, Y, R, G, B) pixels on a valid/ready handshake and clips off-screen coordinates.
- Converts accepted pixels to linear framebuffer addresses and buffers them in a small FIFO.
- Drains the FIFO to the framebuffer SRAM port using a 4-phase req/ack handshake.

Parameters:
- WIDTH, 640, screen width in pixels
- HEIGHT, 480, screen height in pixels
- WIDTH_BITS, 10, X coordinate width
- HEIGHT_BITS, 9, Y coordinate width
- CHANNEL_BITS, 8, bits per colour channel
- ADDR_BITS, 19, framebuffer address width; must satisfy 2^ADDR_BITS >= WIDTH*HEIGHT
- FIFO_DEPTH, 4, pixel FIFO entries; power of two, >= 2

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- px_valid  in  1  pixel present on the px_* inputs
- px_ready  out  1  writer can accept a pixel this cycle
- px_x  in  WIDTH_BITS  pixel X coordinate
- px_y  in  HEIGHT_BITS  pixel Y coordinate
- px_r / px_g / px_b  in  CHANNEL_BITS each  pixel colour
- mem_req  out  1  SRAM write request
- mem_ack  in  1  SRAM write acknowledge
- mem_addr  out  ADDR_BITS  write address
- mem_data  out  3*CHANNEL_BITS  write data {r,g,b}, with r in the MSBs
- idle  out  1  FIFO empty and write FSM in IDLE
- drop_count  out  16  count of clipped pixels, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst is asynchronous and active-low.
- Reset values: px_ready=1, mem_req=0, mem_addr=0, mem_data=0, idle=1, drop_count=0, FIFO empty, FSM=IDLE.
- Reset asserted mid-transfer:
  - All state clears immediately and mem_req drops asynchronously.
  - Buffered pixels are discarded.
- Input handshake:
  - A pixel is accepted on a rising edge where px_valid && px_ready.
  - px_ready = !full, where full is derived from the registered count. A pixel cannot be pushed into a full FIFO even if a pop occurs in the same cycle.
- Clipping:
  - An accepted pixel with px_x >= WIDTH or px_y >= HEIGHT is consumed but not written.
  - Such a pixel is not pushed into the FIFO.
  - drop_count increments by 1 and holds at 16'hFFFF.
- Address computation:
  - mem_addr = px_y*WIDTH + px_x, computed on accept as an unsigned ADDR_BITS value.
  - The address is stored in the FIFO with the packed colour.
  - Intermediates are at least ADDR_BITS wide; the result never wraps for in-range pixels.
- FIFO:
  - Circular buffer with read and write pointers plus a count of width clog2(FIFO_DEPTH)+1.
  - Push and pop in the same cycle leave count unchanged.
  - Pixels are written strictly in acceptance order.
- Write FSM, states IDLE, REQ, RELEASE:
  - IDLE: if FIFO non-empty, load mem_addr and mem_data from the FIFO head, assert mem_req, go to REQ.
  - REQ: hold mem_req=1 with mem_addr and mem_data stable. When mem_ack is sampled 1, pop the FIFO, drive mem_req=0, go to RELEASE.
  - RELEASE: mem_req=0. When mem_ack is sampled 0, go to IDLE.
  - mem_req is registered. A pixel accepted at edge k into an empty FIFO raises mem_req at edge k+1.
  - Minimum cycles per pixel with single-cycle ack: 3 (IDLE, REQ, RELEASE).
- mem_addr and mem_data hold their last values outside REQ.
- idle = (count==0) && (state==IDLE), registered-state based.
- mem_ack asserted while in IDLE is ignored.

Test Plan:
- Single pixel, ack asserted 2 cycles after mem_req:
  - Stimulus: (x=10, y=20, r=AA, g=BB, b=CC) in one valid cycle.
  - Required: mem_req high 1 cycle after accept, mem_addr=12810, mem_data=24'hAABBCC, one pop, idle=1 afterwards.
- Backpressure:
  - Stimulus: mem_ack tied 0, px_valid held high for 6 distinct pixels.
  - Required: exactly 4 accepted, then px_ready=0.
  - Then release ack: the 4 pixels are written in order, px_ready returns to 1.
- Clipping:
  - Stimulus: pixels (640,0), (0,480), (1023,511), then (639,479).
  - Required: drop_count=3, a single write to mem_addr=307199.
- Ordering with simultaneous push/pop:
  - Stimulus: stream 20 pixels (i, i) for i=0..19 with ack responding in 1 cycle.
  - Required: addresses i*641 in order, none lost or duplicated, count never exceeds 4.
- Reset mid-operation:
  - Stimulus: assert n_rst while in REQ with 3 pixels buffered.
  - Required: mem_req=0 immediately, idle=1, drop_count=0, no further writes after reset release.
- drop_count saturation:
  - Stimulus: 65537 off-screen pixels.
  - Required: drop_count=16'hFFFF, no mem_req.
